// File: rtl/lcv_mul_acc_seq.sv
// Streamed dot-product sequencer around a registered 16x16 signed MAC.
// Optional build macro LCV_MUL_ACC_SEQ_SAT_EN selects saturating accumulation instead of wrap-around.
module lcv_mul_acc_seq #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_a,
  input  logic [15:0]            in_b,
  input  logic [32:0]            in_init,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32:0]            out_sum,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_ovf
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                   in_fire;
  logic                   out_fire;
  logic                   out_valid_r;

  logic signed [31:0]     prod_p1;
  logic signed [32:0]     init_p1;
  logic                   first_p1;
  logic                   vld_p1;

  logic signed [32:0]     acc_p2;
  logic                   ovf_p2;
  logic [COUNT_WIDTH-1:0] count;

  logic signed [32:0]     base;
  logic signed [33:0]     sum_wide;
  logic                   add_ovf;
  logic signed [32:0]     acc_nxt;

  // Full-precision 34-bit sum of a 33-bit base and a 32-bit product.
  function automatic logic signed [33:0] add_wide(input logic signed [32:0] a,
                                                   input logic signed [31:0] p);
    logic signed [33:0] aw;
    logic signed [33:0] pw;
    aw = {a[32], a};
    pw = {{2{p[31]}}, p};
    return aw + pw;
  endfunction

  function automatic logic add_overflow(input logic signed [33:0] s);
    return s[33] ^ s[32];
  endfunction

  // Clamp toward the sign of the true (34-bit) sum when it leaves the 33-bit range.
  function automatic logic signed [32:0] saturate(input logic signed [33:0] s);
    logic signed [32:0] r;
    if (!add_overflow(s)) begin
      r = s[32:0];
    end else if (s[33]) begin
      r = {1'b1, 32'h0000_0000};
    end else begin
      r = {1'b0, 32'hFFFF_FFFF};
    end
    return r;
  endfunction

  function automatic logic signed [32:0] wrap(input logic signed [33:0] s);
    return s[32:0];
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] count_inc(input logic [COUNT_WIDTH-1:0] c);
    logic [COUNT_WIDTH-1:0] r;
    r = (c == {COUNT_WIDTH{1'b1}}) ? c : c + 1'b1;
    return r;
  endfunction

  assign in_ready  = (state == ACCUM) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_r && out_ready;

  assign out_valid = out_valid_r;
  assign out_sum   = acc_p2;
  assign out_count = count;
  assign out_ovf   = ovf_p2;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (in_fire && in_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_fire) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      out_valid_r <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_r <= (state_nxt == HOLD);
    end
  end

  // Stage 1: multiply; the first term of a vector carries its init value along.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      prod_p1  <= '0;
      init_p1  <= '0;
    end else begin
      vld_p1 <= in_fire;
      if (in_fire) begin
        prod_p1  <= $signed(in_a) * $signed(in_b);
        init_p1  <= $signed(in_init);
        first_p1 <= (count == '0);
      end
    end
  end

  always_comb begin
    base     = first_p1 ? init_p1 : acc_p2;
    sum_wide = add_wide(base, prod_p1);
    add_ovf  = add_overflow(sum_wide);
`ifdef LCV_MUL_ACC_SEQ_SAT_EN
    acc_nxt  = saturate(sum_wide);
`else
    acc_nxt  = wrap(sum_wide);
`endif
  end

  // Stage 2: accumulate; results are cleared once the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (out_fire) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= acc_nxt;
      ovf_p2 <= (first_p1 ? 1'b0 : ovf_p2) | add_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (out_fire) begin
      count <= '0;
    end else if (in_fire) begin
      count <= count_inc(count);
    end
  end

endmodule

// File: tb/tb_lcv_mul_acc_seq.sv
// Directed bench for lcv_mul_acc_seq; a second instance with COUNT_WIDTH=2 shares the stimulus.
module tb_lcv_mul_acc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [32:0] in_init;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [32:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  logic        in_ready2;
  logic        out_valid2;
  logic [32:0] out_sum2;
  logic [1:0]  out_count2;
  logic        out_ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcv_mul_acc_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_init(in_init), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  lcv_mul_acc_seq #(.COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_init(in_init), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_count(out_count2), .out_ovf(out_ovf2)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int b, input longint init, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_init  = 33'(init);
    in_last  = last;
    chk("in_ready_accum", in_ready, 1);
  endtask

  task automatic finish_vec(input logic signed [63:0] exp_sum, input int exp_cnt,
                            input int exp_cnt2, input logic exp_ovf);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 0);
    @(negedge clk);
    chk("hold_out_valid", out_valid, 1);
    chk("hold_in_ready", in_ready, 0);
    chk("sum", $signed(out_sum), exp_sum);
    chk("count", out_count, exp_cnt);
    chk("count_w2", out_count2, exp_cnt2);
    chk("ovf", out_ovf, exp_ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_fire_out_valid", out_valid, 0);
    chk("post_fire_in_ready", in_ready, 1);
    chk("post_fire_sum_clear", $signed(out_sum), 0);
    chk("post_fire_count_clear", out_count, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_init = '0;
    in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", $signed(out_sum), 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Basic dot product: 10 + 12 - 30
    send(3, 4, 10, 1'b0);
    send(-5, 6, 999, 1'b1);
    finish_vec(-8, 2, 2, 1'b0);

    // Backpressure on a single-term vector
    send(7, -7, 0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_drain_out_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", $signed(out_sum), -49);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_count", out_count, 1);
    end
    @(negedge clk);
    chk("bp_last_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_fire_in_ready", in_ready, 1);
    chk("bp_after_fire_out_valid", out_valid, 0);

    // Overflow: four products of 2^30 reach 2^32
    for (int i = 0; i < 4; i++) send(-32768, -32768, 0, (i == 3));
`ifdef LCV_MUL_ACC_SEQ_SAT_EN
    finish_vec(64'sd4294967295, 4, 3, 1'b1);
`else
    finish_vec(-64'sd4294967296, 4, 3, 1'b1);
`endif

    // Count saturation (visible on the COUNT_WIDTH=2 instance)
    for (int i = 0; i < 6; i++) send(1, 1, 0, (i == 5));
    finish_vec(6, 6, 3, 1'b0);

    // Back-to-back vectors with in_valid held high across the gap
    send(2, 2, 0, 1'b1);
    @(negedge clk);
    in_a = 16'd1; in_b = 16'd1; in_init = 33'd100; in_last = 1'b1;
    chk("b2b_drain_in_ready", in_ready, 0);
    @(negedge clk);
    chk("b2b_a_valid", out_valid, 1);
    chk("b2b_a_sum", $signed(out_sum), 4);
    chk("b2b_a_count", out_count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_turnaround_in_ready", in_ready, 1);
    finish_vec(101, 1, 1, 1'b0);

    // Reset mid-vector discards in-flight work
    send(9, 9, 50, 1'b0);
    send(8, 8, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", $signed(out_sum), 0);
    chk("midrst_count", out_count, 0);
    rst = 1'b0;
    send(5, 5, 0, 1'b1);
    finish_vec(25, 1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
